// File: rtl/neural_network.sv
// Fully-connected feed-forward inference engine over signed fixed-point.
// Layers run one at a time; every neuron of a layer does one MAC per cycle.
package neural_network_pkg;
    typedef enum logic {RELU, LINEAR} act_e;
    typedef struct packed {
        logic [15:0] num_neurons;
        act_e        activation;
    } layer_t;
endpackage

module neural_network
    import neural_network_pkg::*;
#(
    parameter int     INT_WIDTH  = 16,
    parameter int     FRAC_WIDTH = 16,
    parameter int     NUM_LAYERS = 3,
    parameter int     NUM_INPUTS = 10,
    parameter layer_t LAYERS [NUM_LAYERS] =
        '{'{16'd16, RELU}, '{16'd16, RELU}, '{16'd10, RELU}},
    parameter int     NUM_OUTPUTS = int'(LAYERS[NUM_LAYERS-1].num_neurons),
    parameter logic signed [INT_WIDTH+FRAC_WIDTH-1:0] WEIGHT =
        (INT_WIDTH+FRAC_WIDTH)'(1) << FRAC_WIDTH,
    parameter logic signed [INT_WIDTH+FRAC_WIDTH-1:0] BIAS = '0
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic                                           inputs_ready,
    input  logic [NUM_INPUTS-1:0][INT_WIDTH+FRAC_WIDTH-1:0] inputs,
    output logic                                           outputs_ready,
    output logic [NUM_OUTPUTS-1:0][INT_WIDTH+FRAC_WIDTH-1:0] outputs
);

    localparam int W  = INT_WIDTH + FRAC_WIDTH;
    localparam int AW = W + 8;
    localparam int PW = 2 * W;

    function automatic int widest();
        int m;
        m = NUM_INPUTS;
        for (int l = 0; l < NUM_LAYERS; l++)
            if (int'(LAYERS[l].num_neurons) > m)
                m = int'(LAYERS[l].num_neurons);
        return m;
    endfunction

    localparam int MAX_N = widest();
    localparam int IW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int LW    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    localparam logic signed [W-1:0]  FMAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  FMIN   = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [AW-1:0] SAT_HI = AW'(FMAX);
    localparam logic signed [AW-1:0] SAT_LO = AW'(FMIN);

    typedef enum logic [1:0] {IDLE, ACCUMULATE, ACTIVATE, DONE} state_e;

    state_e state_q, state_d;

    logic signed [W-1:0]  lbuf_q [MAX_N];
    logic signed [AW-1:0] acc_q  [MAX_N];
    logic signed [W-1:0]  act_val [MAX_N];
    logic [IW-1:0]        index_q;
    logic [LW-1:0]        layer_q;
    logic                 ready_q;
    logic [NUM_OUTPUTS-1:0][W-1:0] outs_q;

    logic                 capture, acc_en, act_en;
    logic                 is_last, last_idx, relu;
    logic [15:0]          fan_in;
    logic signed [PW-1:0] product;
    logic signed [AW-1:0] contrib;

    assign fan_in   = (layer_q == '0) ? 16'(NUM_INPUTS)
                    : LAYERS[layer_q - LW'(1)].num_neurons;
    assign is_last  = (layer_q == LW'(NUM_LAYERS - 1));
    assign last_idx = (index_q == IW'(fan_in - 16'd1));
    assign relu     = (LAYERS[layer_q].activation == RELU);

    assign product = PW'(lbuf_q[index_q]) * PW'(WEIGHT);
    assign contrib = AW'(product >>> FRAC_WIDTH);

    // Bias, saturate to the fixed range, then optional ReLU.
    for (genvar n = 0; n < MAX_N; n++) begin : g_act
        logic signed [AW-1:0] sum;
        logic signed [W-1:0]  sat;
        assign sum = acc_q[n] + AW'(BIAS);
        assign sat = (sum > SAT_HI) ? FMAX
                   : (sum < SAT_LO) ? FMIN
                   : W'(sum);
        assign act_val[n] = (relu && sat[W-1]) ? '0 : sat;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE:
                if (inputs_ready)
                    state_d = ACCUMULATE;
            ACCUMULATE:
                if (last_idx)
                    state_d = ACTIVATE;
            ACTIVATE:
                state_d = is_last ? DONE : ACCUMULATE;
            default:
                state_d = IDLE;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        acc_en  = 1'b0;
        act_en  = 1'b0;
        unique case (state_q)
            IDLE, DONE: capture = inputs_ready;
            ACCUMULATE: acc_en  = 1'b1;
            ACTIVATE:   act_en  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < MAX_N; n++) begin
                lbuf_q[n] <= '0;
                acc_q[n]  <= '0;
            end
            index_q <= '0;
            layer_q <= '0;
            ready_q <= 1'b0;
            outs_q  <= '0;
        end else begin
            if (capture) begin
                for (int n = 0; n < MAX_N; n++)
                    lbuf_q[n] <= '0;
                for (int n = 0; n < NUM_INPUTS; n++)
                    lbuf_q[n] <= inputs[n];
                ready_q <= 1'b0;
                layer_q <= '0;
                index_q <= '0;
            end
            if (acc_en) begin
                for (int n = 0; n < MAX_N; n++)
                    acc_q[n] <= acc_q[n] + contrib;
                index_q <= index_q + IW'(1);
            end
            if (act_en) begin
                for (int n = 0; n < MAX_N; n++) begin
                    lbuf_q[n] <= act_val[n];
                    acc_q[n]  <= '0;
                end
                index_q <= '0;
                if (is_last) begin
                    for (int k = 0; k < NUM_OUTPUTS; k++)
                        outs_q[k] <= act_val[k];
                    ready_q <= 1'b1;
                end else begin
                    layer_q <= layer_q + LW'(1);
                end
            end
        end
    end

    assign outputs_ready = ready_q;
    assign outputs       = outs_q;

endmodule

// File: tb/tb_neural_network.sv
// Directed and randomized checks of neural_network against an
// array-based arithmetic model of the layer stack.
module tb_neural_network;
    import neural_network_pkg::*;

    localparam int F  = 16;
    localparam int W  = 32;
    localparam int NI = 10;
    localparam int NL = 3;
    localparam int NO = 10;
    localparam layer_t LAY [NL] =
        '{'{16'd16, RELU}, '{16'd16, RELU}, '{16'd10, RELU}};
    localparam longint WGT  = 65536;
    localparam longint BIA  = 0;
    localparam longint FHI  = 64'sd2147483647;
    localparam longint FLO  = -64'sd2147483648;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic inputs_ready = 1'b0;
    logic [NI-1:0][W-1:0] inputs = '0;
    logic outputs_ready;
    logic [NO-1:0][W-1:0] outputs;

    int compared   = 0;
    int mismatched = 0;

    neural_network dut (
        .clock         (clock),
        .reset         (reset),
        .inputs_ready  (inputs_ready),
        .inputs        (inputs),
        .outputs_ready (outputs_ready),
        .outputs       (outputs)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [NO*W-1:0] obs,
                         input logic [NO*W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [NI-1:0][W-1:0] x,
                                  output logic [NO-1:0][W-1:0] y);
        longint cur[$];
        longint nxt[$];
        longint s;
        cur = {};
        for (int i = 0; i < NI; i++)
            cur.push_back(longint'($signed(x[i])));
        for (int l = 0; l < NL; l++) begin
            nxt = {};
            for (int n = 0; n < int'(LAY[l].num_neurons); n++) begin
                s = 0;
                foreach (cur[i])
                    s += (cur[i] * WGT) >>> F;
                s += BIA;
                if (s > FHI) s = FHI;
                if (s < FLO) s = FLO;
                if (LAY[l].activation == RELU && s < 0) s = 0;
                nxt.push_back(s);
            end
            cur = nxt;
        end
        for (int k = 0; k < NO; k++)
            y[k] = W'(cur[k]);
    endfunction

    function automatic int latency();
        int t, fi;
        t = 0;
        for (int l = 0; l < NL; l++) begin
            fi = (l == 0) ? NI : int'(LAY[l-1].num_neurons);
            t += fi + 1;
        end
        return t;
    endfunction

    function automatic logic [NI-1:0][W-1:0] fill(input logic [W-1:0] v);
        logic [NI-1:0][W-1:0] r;
        for (int i = 0; i < NI; i++)
            r[i] = v;
        return r;
    endfunction

    function automatic logic [NI-1:0][W-1:0] rnd_vec();
        logic [NI-1:0][W-1:0] r;
        for (int i = 0; i < NI; i++)
            r[i] = $urandom_range(0, 32'h003F_FFFF) - 32'h0020_0000;
        return r;
    endfunction

    task automatic run(input logic [NI-1:0][W-1:0] x, input int pulse_at,
                       input string tag);
        logic [NO-1:0][W-1:0] exp;
        int cyc;
        model(x, exp);
        @(negedge clock);
        inputs = x;
        inputs_ready = 1'b1;
        @(posedge clock);
        #1;
        inputs_ready = 1'b0;
        inputs = rnd_vec();
        check({tag, "/ready_drop"}, NO*W'(outputs_ready), '0);
        cyc = 0;
        while (!outputs_ready && cyc < 200) begin
            inputs_ready = (cyc == pulse_at);
            @(posedge clock);
            #1;
            cyc++;
        end
        inputs_ready = 1'b0;
        check({tag, "/latency"}, NO*W'(cyc), NO*W'(latency()));
        for (int k = 0; k < NO; k++)
            check($sformatf("%s/out%0d", tag, k), NO*W'(outputs[k]),
                  NO*W'(exp[k]));
        repeat (3) @(posedge clock);
        #1;
        check({tag, "/hold"}, outputs, exp);
        check({tag, "/hold_ready"}, NO*W'(outputs_ready), NO*W'(1));
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset/ready", NO*W'(outputs_ready), '0);
        check("reset/outputs", outputs, '0);
        @(negedge clock);
        reset = 1'b1;

        run(fill(32'h0001_0000), -1, "ones");
        check("ones/value", NO*W'(outputs[0]), NO*W'(32'h0A00_0000));
        run(fill(32'h0000_0000), -1, "zeros");
        check("zeros/value", NO*W'(outputs[9]), '0);
        run(fill(32'hFFFF_0000), -1, "neg_ones");
        check("neg_ones/value", NO*W'(outputs[3]), '0);
        run(fill(32'h03E8_0000), -1, "big");
        check("big/value", NO*W'(outputs[5]), NO*W'(32'h7FFF_FFFF));
        run(fill(32'h0000_8000), -1, "half");
        check("half/value", NO*W'(outputs[0]), NO*W'(32'h0500_0000));
        run(fill(32'h0000_8000), 20, "half_pulse");
        check("half_pulse/value", NO*W'(outputs[7]), NO*W'(32'h0500_0000));

        for (int r = 0; r < 4; r++)
            run(rnd_vec(), (r % 2 == 0) ? -1 : int'($urandom_range(2, 40)),
                $sformatf("rand%0d", r));

        run(fill(32'h0001_0000), -1, "pre_reset");
        @(negedge clock);
        inputs = fill(32'h0001_0000);
        inputs_ready = 1'b1;
        @(posedge clock);
        #1;
        inputs_ready = 1'b0;
        repeat (20) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("midreset/ready", NO*W'(outputs_ready), '0);
        check("midreset/outputs", outputs, '0);
        @(negedge clock);
        reset = 1'b1;
        run(fill(32'h0001_0000), -1, "after_reset");
        check("after_reset/value", NO*W'(outputs[9]), NO*W'(32'h0A00_0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
